// File: rtl/vector_op_sequencer_pkg.sv
// Shared types and constants for the vector coprocessor BRAM sequencer.
//   op_e      : encoded operation (op_sel carries the compute values 3..7)
//   CMD_*     : bit positions inside the one-hot command_in vector
//   state_e   : sequencer FSM states
//   tok_t     : read-pipe token {valid, first, last}
package vector_op_sequencer_pkg;

  localparam int unsigned CMD_W      = 7;
  localparam int unsigned CMD_WRITE  = 6;
  localparam int unsigned CMD_READ   = 5;
  localparam int unsigned CMD_SUM    = 4;
  localparam int unsigned CMD_AVG    = 3;
  localparam int unsigned CMD_EUC    = 2;
  localparam int unsigned CMD_MAN    = 1;
  localparam int unsigned CMD_DOT    = 0;

  localparam int unsigned N_ELEM_DEF = 1024;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_WRITE = 3'd1,
    OP_READ  = 3'd2,
    OP_SUM   = 3'd3,
    OP_AVG   = 3'd4,
    OP_EUC   = 3'd5,
    OP_MAN   = 3'd6,
    OP_DOT   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_WAIT_CLR
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tok_t;

  // Command bit owned by an operation: op code n lives at bit 7-n.
  function automatic logic [2:0] cmd_bit(op_e op);
    return 3'd7 - op;
  endfunction

  // Only meaningful when exactly one compute bit is set.
  function automatic op_e cmd_to_op(logic [CMD_W-1:0] cmd);
    op_e op;
    op = OP_SUM;
    if (cmd[CMD_AVG]) op = OP_AVG;
    if (cmd[CMD_EUC]) op = OP_EUC;
    if (cmd[CMD_MAN]) op = OP_MAN;
    if (cmd[CMD_DOT]) op = OP_DOT;
    return op;
  endfunction

endpackage

// File: rtl/vector_op_sequencer_if.sv
// Bundle of command, UART byte, BRAM port and datapath element signals.
//   master : command decoder / UART / BRAM / datapath side
//   slave  : vector_op_sequencer side
interface vector_op_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic [6:0]        command_in;
  logic              bram_sel_in;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              bram_a_we;
  logic              bram_b_we;
  logic [DATA_W-1:0] bram_a_rdata;
  logic [DATA_W-1:0] bram_b_rdata;
  logic              elem_valid;
  logic [DATA_W-1:0] elem_a;
  logic [DATA_W-1:0] elem_b;
  logic              elem_first;
  logic              elem_last;
  logic [2:0]        op_sel;
  logic              busy;
  logic              write_done;
  logic              op_done;
  logic              cmd_err;

  modport master (
    output command_in, bram_sel_in, rx_valid, rx_data, bram_a_rdata, bram_b_rdata,
    input  bram_addr, bram_wdata, bram_a_we, bram_b_we, elem_valid, elem_a, elem_b,
           elem_first, elem_last, op_sel, busy, write_done, op_done, cmd_err
  );

  modport slave (
    input  command_in, bram_sel_in, rx_valid, rx_data, bram_a_rdata, bram_b_rdata,
    output bram_addr, bram_wdata, bram_a_we, bram_b_we, elem_valid, elem_a, elem_b,
           elem_first, elem_last, op_sel, busy, write_done, op_done, cmd_err
  );
endinterface

// File: rtl/vector_op_sequencer_rd_valid_pipe.sv
// DEPTH-stage shift register of read tokens that tracks BRAM read latency.
//   clk, reset : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of every stage
//   tok_i      : token for the address presented this cycle
//   tok_o      : token whose read data is on the BRAM outputs this cycle
module rd_valid_pipe
  import vector_op_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  tok_t tok_i,
  output tok_t tok_o
);

  tok_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tok_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tok_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vector_op_sequencer.sv
// Sequencer for the shared BRAM A/B address port of the vector coprocessor.
// Write2dev stores N_ELEM UART bytes into BRAM A or B; compute ops stream
// (A[k],B[k]) pairs to the datapath and report op_done after DP_LAT cycles.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : command, UART, BRAM and element signals (slave modport)
module vector_op_sequencer
  import vector_op_sequencer_pkg::*;
#(
  parameter int unsigned N_ELEM = N_ELEM_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned DP_LAT = 3
) (
  input logic                 clk,
  input logic                 reset,
  vector_op_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);
  localparam int unsigned       DLY_W     = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [DLY_W-1:0]  DLY_END   = DLY_W'(DP_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              a_we_q, a_we_d, b_we_q, b_we_d;
  logic              sel_q, sel_d;
  op_e               op_q, op_d;
  op_e               op_sel_q, op_sel_d;
  logic              seen_q, seen_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              busy_q, busy_d;
  logic              wd_q, wd_d, od_q, od_d, ce_q, ce_d;
  logic              ev_q, ev_d, ef_q, ef_d, el_q, el_d;
  logic [DATA_W-1:0] ea_q, ea_d, eb_q, eb_d;

  tok_t              tok_in, tok_out;
  logic              flush;
  logic [2:0]        n_hot;
  logic              active_on;

  rd_valid_pipe #(.DEPTH(RD_LAT)) u_rd_valid_pipe (
    .clk    (clk),
    .reset  (reset),
    .flush_i(flush),
    .tok_i  (tok_in),
    .tok_o  (tok_out)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    a_we_d   = 1'b0;
    b_we_d   = 1'b0;
    sel_d    = sel_q;
    op_d     = op_q;
    op_sel_d = op_sel_q;
    seen_d   = seen_q;
    dly_d    = dly_q;
    wd_d     = 1'b0;
    od_d     = 1'b0;
    ce_d     = 1'b0;
    tok_in   = '0;
    flush    = 1'b0;

    n_hot     = 3'($countones(bus.command_in));
    active_on = bus.command_in[cmd_bit(op_q)];

    case (state_q)
      S_IDLE: begin
        if (n_hot > 3'd1) begin
          ce_d = 1'b1;
        end else if (bus.command_in[CMD_WRITE]) begin
          sel_d   = bus.bram_sel_in;
          op_d    = OP_WRITE;
          cnt_d   = '0;
          addr_d  = '0;
          state_d = S_WRITE;
        end else if (n_hot == 3'd1 && !bus.command_in[CMD_READ]) begin
          op_d     = cmd_to_op(bus.command_in);
          op_sel_d = cmd_to_op(bus.command_in);
          addr_d   = '0;
          seen_d   = 1'b0;
          dly_d    = '0;
          state_d  = S_ISSUE;
        end
      end

      S_WRITE: begin
        if (!active_on) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.rx_valid) begin
          addr_d  = cnt_q;
          wdata_d = bus.rx_data;
          a_we_d  = !sel_q;
          b_we_d  = sel_q;
          if (cnt_q == LAST_ADDR) state_d = S_DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end

      S_ISSUE: begin
        if (!active_on) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tok_in = '{valid: 1'b1, first: (addr_q == '0), last: (addr_q == LAST_ADDR)};
          if (addr_q == LAST_ADDR) state_d = S_DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
      end

      // dly counts cycles from the elem_last cycle; DONE lands DP_LAT cycles
      // after it so op_done appears DP_LAT+1 cycles after elem_last.
      S_DRAIN: begin
        if (!active_on) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (el_q || seen_q) begin
          if (dly_q == DLY_END) begin
            state_d = S_DONE;
          end else begin
            dly_d  = dly_q + 1'b1;
            seen_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        wd_d    = (op_q == OP_WRITE);
        od_d    = (op_q != OP_WRITE);
        state_d = S_WAIT_CLR;
      end

      S_WAIT_CLR: begin
        if (bus.command_in == '0) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    ev_d   = tok_out.valid && !flush;
    ef_d   = ev_d && tok_out.first;
    el_d   = ev_d && tok_out.last;
    ea_d   = ev_d ? bus.bram_a_rdata : '0;
    eb_d   = ev_d ? bus.bram_b_rdata : '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      a_we_q   <= 1'b0;
      b_we_q   <= 1'b0;
      sel_q    <= 1'b0;
      op_q     <= OP_NONE;
      op_sel_q <= OP_NONE;
      seen_q   <= 1'b0;
      dly_q    <= '0;
      busy_q   <= 1'b0;
      wd_q     <= 1'b0;
      od_q     <= 1'b0;
      ce_q     <= 1'b0;
      ev_q     <= 1'b0;
      ef_q     <= 1'b0;
      el_q     <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      a_we_q   <= a_we_d;
      b_we_q   <= b_we_d;
      sel_q    <= sel_d;
      op_q     <= op_d;
      op_sel_q <= op_sel_d;
      seen_q   <= seen_d;
      dly_q    <= dly_d;
      busy_q   <= busy_d;
      wd_q     <= wd_d;
      od_q     <= od_d;
      ce_q     <= ce_d;
      ev_q     <= ev_d;
      ef_q     <= ef_d;
      el_q     <= el_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
    end
  end

  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.bram_a_we  = a_we_q;
  assign bus.bram_b_we  = b_we_q;
  assign bus.elem_valid = ev_q;
  assign bus.elem_a     = ea_q;
  assign bus.elem_b     = eb_q;
  assign bus.elem_first = ef_q;
  assign bus.elem_last  = el_q;
  assign bus.op_sel     = op_sel_q;
  assign bus.busy       = busy_q;
  assign bus.write_done = wd_q;
  assign bus.op_done    = od_q;
  assign bus.cmd_err    = ce_q;

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Directed bench for vector_op_sequencer with a two-stage BRAM read model.
module tb_vector_op_sequencer;
  localparam int unsigned N      = 1024;
  localparam int unsigned DW     = 8;
  localparam int unsigned AW     = 10;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DP_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_op_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  vector_op_sequencer #(
    .N_ELEM(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT), .DP_LAT(DP_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // BRAM model: read data appears two cycles after the address.
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  logic [DW-1:0] a_s1, b_s1;
  always @(posedge clk) begin
    if (bus.bram_a_we) mem_a[bus.bram_addr] <= bus.bram_wdata;
    if (bus.bram_b_we) mem_b[bus.bram_addr] <= bus.bram_wdata;
    a_s1 <= mem_a[bus.bram_addr];
    b_s1 <= mem_b[bus.bram_addr];
    bus.bram_a_rdata <= a_s1;
    bus.bram_b_rdata <= b_s1;
  end

  // Event monitor, sampled on the falling edge.
  logic mon_clr = 1'b0;
  int   wr_mult = 1;
  int   a_we_n, b_we_n, wr_idx, wr_err, t_lastwr, wd_n, t_wd;
  int   elem_n, el_idx, elem_err, first_n, last_n, t_first, t_last, t_lastv;
  int   od_n, t_od, ce_n, rise_n, t_rise;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    busy_prev <= bus.busy;
    if (mon_clr) begin
      a_we_n <= 0; b_we_n <= 0; wr_idx <= 0; wr_err <= 0; t_lastwr <= 0;
      wd_n <= 0; t_wd <= 0; elem_n <= 0; el_idx <= 0; elem_err <= 0;
      first_n <= 0; last_n <= 0; t_first <= 0; t_last <= 0; t_lastv <= 0;
      od_n <= 0; t_od <= 0; ce_n <= 0; rise_n <= 0; t_rise <= 0;
    end else begin
      if (bus.bram_a_we || bus.bram_b_we) begin
        if (bus.bram_a_we) a_we_n <= a_we_n + 1;
        if (bus.bram_b_we) b_we_n <= b_we_n + 1;
        if (bus.bram_addr != AW'(wr_idx) || bus.bram_wdata != DW'(wr_idx * wr_mult))
          wr_err <= wr_err + 1;
        if (wr_idx == N - 1) t_lastwr <= cyc;
        wr_idx <= wr_idx + 1;
      end
      if (bus.write_done) begin wd_n <= wd_n + 1; t_wd <= cyc; end
      if (bus.elem_valid) begin
        elem_n <= elem_n + 1;
        if (bus.elem_a != DW'(el_idx) || bus.elem_b != DW'(2 * el_idx)) elem_err <= elem_err + 1;
        el_idx  <= el_idx + 1;
        t_lastv <= cyc;
        if (bus.elem_first) begin first_n <= first_n + 1; t_first <= cyc; end
        if (bus.elem_last)  begin last_n  <= last_n + 1;  t_last  <= cyc; end
      end
      if (bus.op_done) begin od_n <= od_n + 1; t_od <= cyc; end
      if (bus.cmd_err) ce_n <= ce_n + 1;
      if (bus.busy && !busy_prev) begin rise_n <= rise_n + 1; t_rise <= cyc; end
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  function automatic longint all_outs();
    return 64'({bus.bram_addr, bus.bram_wdata, bus.bram_a_we, bus.bram_b_we, bus.elem_valid,
                bus.elem_a, bus.elem_b, bus.elem_first, bus.elem_last, bus.op_sel, bus.busy,
                bus.write_done, bus.op_done, bus.cmd_err});
  endfunction

  task automatic load_bram(input logic sel, input int mult);
    clear_mon();
    wr_mult         = mult;
    bus.bram_sel_in = sel;
    bus.command_in  = 7'b1000000;
    tick(1);
    for (int k = 0; k < N; k++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = DW'(k * mult);
      tick(1);
      bus.rx_valid = 1'b0;
      if (k % 4 == 3) tick(1);
    end
    tick(6);
    bus.command_in = '0;
    tick(2);
  endtask

  task automatic wait_addr(input int target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick(1);
      if (bus.busy && bus.bram_addr == AW'(target)) found = 1'b1;
    end
  endtask

  bit found;
  int t_drop;

  initial begin
    reset           = 1'b0;
    bus.command_in  = '0;
    bus.bram_sel_in = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = '0;
    tick(3);
    check("reset_outs", all_outs(), 0);
    reset = 1'b1;
    tick(2);

    // Reset asserted in the middle of a streaming op.
    clear_mon();
    bus.command_in = 7'b0010000;
    wait_addr(37, found);
    check("rst_found_addr37", found, 1);
    check("rst_pre_elem_valid", bus.elem_valid, 1);
    reset = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 0);
    bus.command_in = '0;
    tick(2);
    reset = 1'b1;
    tick(3);
    check("rst_idle_busy", bus.busy, 0);

    // Write 1024 bytes into BRAM B.
    load_bram(1'b1, 1);
    check("wr_b_count", b_we_n, N);
    check("wr_a_count", a_we_n, 0);
    check("wr_addr_data_err", wr_err, 0);
    check("wr_done_count", wd_n, 1);
    check("wr_done_lat", t_wd - t_lastwr, 1);
    check("wr_busy_after", bus.busy, 0);

    // Preload A[k]=k, B[k]=2k.
    load_bram(1'b0, 1);
    check("ld_a_count", a_we_n, N);
    check("ld_a_err", wr_err, 0);
    load_bram(1'b1, 2);
    check("ld_b_err", wr_err, 0);

    // Sum op, command held past op_done.
    clear_mon();
    bus.command_in = 7'b0010000;
    tick(N + 20);
    check("sum_elem_count", elem_n, N);
    check("sum_elem_data_err", elem_err, 0);
    check("sum_first_count", first_n, 1);
    check("sum_last_count", last_n, 1);
    check("sum_first_lat", t_first - t_rise, RD_LAT + 1);
    check("sum_contiguous", t_last - t_first, N - 1);
    check("sum_opdone_lat", t_od - t_last, DP_LAT + 1);
    check("sum_opdone_count", od_n, 1);
    check("sum_op_sel", bus.op_sel, 3);
    check("hold_busy", bus.busy, 1);
    check("hold_no_restart", rise_n, 1);
    bus.command_in = '0;
    tick(2);
    check("hold_busy_drop", bus.busy, 0);
    check("hold_opdone_once", od_n, 1);

    // Dot op aborted at address 500.
    clear_mon();
    bus.command_in = 7'b0000001;
    wait_addr(500, found);
    t_drop = cyc;
    bus.command_in = '0;
    tick(20);
    check("abort_found_addr500", found, 1);
    check("abort_elem_stop", (t_lastv - t_drop <= int'(RD_LAT + 1)) ? 1 : 0, 1);
    check("abort_elem_data_err", elem_err, 0);
    check("abort_no_opdone", od_n, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_op_sel", bus.op_sel, 7);

    // Multi-hot command and read-only command.
    clear_mon();
    bus.command_in = 7'b0011000;
    tick(1);
    bus.command_in = '0;
    tick(3);
    check("cmderr_count", ce_n, 1);
    check("cmderr_no_busy", rise_n, 0);
    bus.command_in = 7'b0100000;
    tick(5);
    bus.command_in = '0;
    tick(2);
    check("read_no_busy", rise_n, 0);
    check("read_no_we", a_we_n + b_we_n, 0);
    check("read_no_elem", elem_n, 0);
    check("read_no_cmderr", ce_n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
